// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU data-memory port.
// Word-organised RAM with byte-lane writes, a programmable access latency and a
// combinational stall that holds the core's MEM stage until the response cycle.
// Optional feature macro DMEM_MMIO_EN: maps byte address 32'hBFAF_F000 onto a
// 16-bit LED register instead of RAM.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [15:0] mmio_led
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]       ram [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mmio_q, mmio_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ram_we;
    logic [31:0]       merged;
    logic              req_mmio;

    // Low address bits select a byte within the word; high bits alias the RAM.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef DMEM_MMIO_EN
    logic [15:0] led_q, led_d;
    logic [31:0] led_word;
    assign req_mmio = (mem_addr == 32'hBFAF_F000);
    assign mmio_led = led_q;
`else
    assign req_mmio = 1'b0;
    assign mmio_led = 16'h0000;
`endif

    // Next-state, request capture and commit of the write-first response word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        mmio_d  = mmio_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;
        merged  = merge_lanes(ram[widx_q], wdata_q, wen_q);
`ifdef DMEM_MMIO_EN
        led_d    = led_q;
        led_word = merge_lanes({16'h0000, led_q}, wdata_q, {2'b00, wen_q[1:0]});
`endif
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    widx_d  = mem_addr[ADDR_W+1:2];
                    wen_d   = mem_wen;
                    wdata_d = mem_wdata;
                    mmio_d  = req_mmio;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (mmio_q) begin
`ifdef DMEM_MMIO_EN
                        led_d   = led_word[15:0];
                        rdata_d = led_word;
`endif
                    end else begin
                        ram_we  = |wen_q;
                        rdata_d = merged;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers; captured request fields need no reset.
    always_ff @(posedge clk) begin
        widx_q  <= widx_d;
        wen_q   <= wen_d;
        wdata_q <= wdata_d;
        mmio_q  <= mmio_d;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_MMIO_EN
    // LED register updates only at commit of an MMIO store.
    always_ff @(posedge clk) begin
        if (rst) led_q <= 16'h0000;
        else     led_q <= led_d;
    end
`endif

    // RAM array; a reset in the commit cycle discards the store.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) ram[widx_q] <= merged;
    end

    assign mem_rdata = rdata_q;
    assign mem_stall = !rst && ((state_q == IDLE && mem_en) || state_q == BUSY);

endmodule
